uart_msg_arbiter: RTL and testbench

Shares one UART 8N1 transmitter between NREQ message producers, such as the keyboard, mouse, gamepad and raw-report printers. Each producer offers a byte stream with valid/ready handshakes and a last flag that marks the end of a message. The arbiter grants whole messages in round-robin order, so text from different producers never interleaves on the line. It contains the baud generator and the serializer, and drives the board's uart_tx pin directly.

---
 rtl/uart_msg_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_uart_msg_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter
//   Shares one UART 8N1 transmitter between NREQ byte-stream producers.
//   Whole messages are granted in round-robin order, so messages from
//   different producers never interleave on the line. The block holds the
//   baud generator and the serializer, and it drives uart_tx directly.
//
// Parameters
//   CLK_HZ, BAUD  : bit period DIV = CLK_HZ/BAUD cycles (DIV >= 2)
//   NREQ          : number of requesters (2..8)
//   TIMEOUT_CYC   : idle GRANT cycles inside a message before the grant is revoked
//
// Ports
//   clk, resetn   : clock, synchronous active-low reset
//   req_valid     : per-requester byte valid
//   req_data      : byte of requester i on [8i+7:8i]
//   req_last      : marks the final byte of a message
//   req_ready     : per-requester accept (one-hot or zero)
//   uart_tx       : serial line, idles high
//   busy          : arbiter not idle
//   grant_valid   : a grant is held
//   grant_id      : granted requester (meaningful while grant_valid)
//   timeout_err   : one-cycle pulse when a grant is revoked by timeout
//
// Build option
//   UART_ARB_AUTO_CRLF_EN : append 0x0D, 0x0A after each message's last byte
//                           before the grant is released.
module uart_msg_arbiter #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic              grant_valid,
    output logic [2:0]        grant_id,
    output logic              timeout_err
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ICW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, SHIFT} state_t;
    state_t state, state_nxt;

`ifdef UART_ARB_AUTO_CRLF_EN
    typedef enum logic [1:0] {CRLF_NONE, CRLF_CR, CRLF_LF} crlf_t;
    crlf_t      crlf_ph;
    logic       crlf_more;
    logic [7:0] crlf_byte;
`endif

    logic [2:0]     rr_ptr;
    logic [BCW-1:0] baud_cnt;
    logic [3:0]     bit_idx;
    logic [7:0]     shreg;
    logic           tx_last;
    logic [ICW-1:0] idle_cnt;

    logic       win_found;
    logic [2:0] win_id;
    logic       gnt_valid;
    logic [7:0] gnt_data;
    logic       gnt_last;
    logic       handshake;
    logic       timeout_hit;
    logic       bit_end;
    logic       frame_end;
    logic       msg_done;

    always_comb begin
        win_found   = 1'b0;
        win_id      = '0;
        gnt_valid   = 1'b0;
        gnt_data    = '0;
        gnt_last    = 1'b0;
        req_ready   = '0;
        state_nxt   = state;

        // Walk offsets from farthest to nearest so the requester closest
        // after rr_ptr is the last one written and therefore wins.
        for (int unsigned i = NREQ; i >= 1; i--) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (req_valid[j] && ((32'(rr_ptr) + i) % NREQ) == j) begin
                    win_found = 1'b1;
                    win_id    = 3'(j);
                end
            end
        end

        for (int unsigned j = 0; j < NREQ; j++) begin
            if (grant_id == 3'(j)) begin
                gnt_valid    = req_valid[j];
                gnt_data     = req_data[8*j +: 8];
                gnt_last     = req_last[j];
                req_ready[j] = (state == GRANT);
            end
        end

        busy        = (state != IDLE);
        handshake   = (state == GRANT) && gnt_valid;
        timeout_hit = (state == GRANT) && !gnt_valid
                      && (idle_cnt == ICW'(TIMEOUT_CYC - 1));
        bit_end     = (baud_cnt == BCW'(DIV - 1));
        frame_end   = (state == SHIFT) && bit_end && (bit_idx == 4'd9);
`ifdef UART_ARB_AUTO_CRLF_EN
        crlf_more   = frame_end && tx_last && (crlf_ph != CRLF_LF);
        msg_done    = frame_end && tx_last && (crlf_ph == CRLF_LF);
        crlf_byte   = (crlf_ph == CRLF_NONE) ? 8'h0D : 8'h0A;
`else
        msg_done    = frame_end && tx_last;
`endif

        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT: begin
                if (handshake)        state_nxt = SHIFT;
                else if (timeout_hit) state_nxt = IDLE;
            end
            SHIFT: begin
                // A last byte that is not yet done only occurs while the
                // CR/LF trailer is still pending, which stays in SHIFT.
                if (msg_done)                    state_nxt = IDLE;
                else if (frame_end && !tx_last)  state_nxt = GRANT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_tx     <= 1'b1;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= 3'(NREQ - 1);
            idle_cnt    <= '0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            tx_last     <= 1'b0;
`ifdef UART_ARB_AUTO_CRLF_EN
            crlf_ph     <= CRLF_NONE;
`endif
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    idle_cnt <= '0;
                    if (win_found) begin
                        grant_valid <= 1'b1;
                        grant_id    <= win_id;
                        rr_ptr      <= win_id;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        uart_tx  <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        shreg    <= gnt_data;
                        tx_last  <= gnt_last;
                        idle_cnt <= '0;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        grant_valid <= 1'b0;
                        idle_cnt    <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            // Shifting in ones makes the stop bit fall out
                            // of the register after the eighth data bit.
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= shreg[0];
                            shreg   <= {1'b1, shreg[7:1]};
                        end
`ifdef UART_ARB_AUTO_CRLF_EN
                        else if (crlf_more) begin
                            uart_tx <= 1'b0;
                            bit_idx <= '0;
                            shreg   <= crlf_byte;
                            crlf_ph <= (crlf_ph == CRLF_NONE) ? CRLF_CR : CRLF_LF;
                        end
`endif
                        else if (msg_done) begin
                            grant_valid <= 1'b0;
`ifdef UART_ARB_AUTO_CRLF_EN
                            crlf_ph     <= CRLF_NONE;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb_uart_msg_arbiter
//   Directed bench for uart_msg_arbiter with DIV=8 (80-cycle frames),
//   NREQ=4 and TIMEOUT_CYC=16. A producer model feeds per-requester byte
//   queues, a line decoder rebuilds frames from uart_tx, and a grant logger
//   records grant order and timing.
module tb_uart_msg_arbiter;

    localparam int DIV   = 8;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        uart_tx;
    logic        busy;
    logic        grant_valid;
    logic [2:0]  grant_id;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_msg_arbiter #(
        .CLK_HZ(8),
        .BAUD(1),
        .NREQ(4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx(uart_tx),
        .busy(busy),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // producer queue entries: {requester[2:0], last, data[7:0]}
    logic [11:0] pq[$];
    logic [3:0]  hs = '0;

    // monitor state and logs
    int          cyc = 0;
    logic        in_frame = 1'b0;
    int          pos = 0;
    int          ph;
    logic        lvl = 1'b1;
    logic [7:0]  rx_byte = '0;
    int          rx_start_c = 0;
    logic [2:0]  rx_gid_c = '0;
    logic [7:0]  rx_q[$];
    int          rx_s[$];
    logic [2:0]  rx_g[$];
    logic [2:0]  gnt_q[$];
    int          gnt_c[$];
    int          to_c[$];
    logic        to_gv = 1'b0;
    int          gv_fall = -1;
    logic        prev_gv = 1'b0;
    int          frame_err = 0;
    int          multi_rdy = 0;
    int          rdy0_cnt = 0;

    logic [2:0]  t3_g [5] = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd3};
    logic [7:0]  t3_d [5] = '{8'h10, 8'h11, 8'h13, 8'h20, 8'h23};
    logic [7:0]  t4_d [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};

    function automatic int head_idx(input int r);
        for (int k = 0; k < pq.size(); k++)
            if (pq[k][11:9] == 3'(r)) return k;
        return -1;
    endfunction

    // Monitor and producer, both evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) in_frame = 1'b0;
            if (grant_valid && !prev_gv) begin
                gnt_q.push_back(grant_id);
                gnt_c.push_back(cyc);
            end
            if (!grant_valid && prev_gv) gv_fall = cyc;
            prev_gv = grant_valid;
            if (timeout_err) begin
                to_c.push_back(cyc);
                to_gv = grant_valid;
            end
            if ($countones(req_ready) > 1) multi_rdy++;
            if (req_ready[0]) rdy0_cnt++;

            if (!in_frame && resetn && uart_tx == 1'b0) begin
                in_frame   = 1'b1;
                pos        = 0;
                rx_start_c = cyc;
                rx_gid_c   = grant_id;
            end
            if (in_frame) begin
                ph = pos % DIV;
                if (ph == 0) lvl = uart_tx;
                else if (uart_tx !== lvl) frame_err++;
                if (ph == DIV - 1) begin
                    if (pos / DIV == 0 && lvl !== 1'b0) frame_err++;
                    else if (pos / DIV == 9 && lvl !== 1'b1) frame_err++;
                    else if (pos / DIV != 9) rx_byte = {lvl, rx_byte[7:1]};
                end
                pos++;
                if (pos == FRAME) begin
                    rx_q.push_back(rx_byte);
                    rx_s.push_back(rx_start_c);
                    rx_g.push_back(rx_gid_c);
                    in_frame = 1'b0;
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    int k;
                    k = head_idx(i);
                    if (k >= 0) pq.delete(k);
                end
            end
            for (int i = 0; i < 4; i++) begin
                int k;
                k = head_idx(i);
                req_valid[i] = (k >= 0);
                if (k >= 0) begin
                    req_data[8*i +: 8] = pq[k][7:0];
                    req_last[i]        = pq[k][8];
                end else begin
                    req_data[8*i +: 8] = '0;
                    req_last[i]        = 1'b0;
                end
                hs[i] = req_valid[i] && req_ready[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        pq.push_back({3'(r), last, d});
    endtask

    task automatic clear_logs();
        rx_q.delete(); rx_s.delete(); rx_g.delete();
        gnt_q.delete(); gnt_c.delete(); to_c.delete();
        gv_fall  = -1;
        rdy0_cnt = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        pq.delete();
        hs = '0;
        tick(3);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    initial begin
        // power-up reset values
        tick(3);
        chk("rst_tx", uart_tx, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gv", grant_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_to", timeout_err, 0);
        resetn = 1'b1;
        tick(1);

        // 1: reset in the middle of a frame
        do_reset();
        clear_logs();
        push(2, 1'b1, 8'h55);
        tick(25);
        chk("t1_in_frame", in_frame, 1);
        chk("t1_gid_pre", grant_id, 2);
        resetn = 1'b0;
        pq.delete();
        hs = '0;
        tick(1);
        chk("t1_rst_tx", uart_tx, 1);
        chk("t1_rst_ready", req_ready, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_gv", grant_valid, 0);
        chk("t1_rst_gid", grant_id, 0);
        chk("t1_rst_to", timeout_err, 0);
        tick(2);
        resetn = 1'b1;
        tick(30);
        chk("t1_no_replay", rx_q.size(), 0);
        chk("t1_idle_gv", grant_valid, 0);
        chk("t1_idle_tx", uart_tx, 1);
        clear_logs();
        push(2, 1'b1, 8'h66);
        wait_rx("t1_rx_cnt", 1, 200);
        chk("t1_byte", rx_q[0], 8'h66);
        chk("t1_start_after_grant", rx_s[0], gnt_c[0] + 1);

        // 2: single two-byte message from requester 2
        do_reset();
        clear_logs();
        push(2, 1'b0, 8'h41);
        push(2, 1'b1, 8'h42);
        tick(40);
        chk("t2_busy", busy, 1);
        chk("t2_gid_mid", grant_id, 2);
        wait_rx("t2_rx_cnt", 2, 300);
        tick(3);
        chk("t2_b0", rx_q[0], 8'h41);
        chk("t2_b1", rx_q[1], 8'h42);
        chk("t2_spacing", rx_s[1] - rx_s[0], 81);
        chk("t2_gid0", rx_g[0], 2);
        chk("t2_gid1", rx_g[1], 2);
        chk("t2_gv_fall", gv_fall, rx_s[1] + FRAME);
        chk("t2_grants", gnt_q.size(), 1);
        chk("t2_idle_busy", busy, 0);

        // 3: round-robin over 0,1,3 then 0 and 3 with rr_ptr=3
        do_reset();
        clear_logs();
        push(0, 1'b1, 8'h10);
        push(1, 1'b1, 8'h11);
        push(3, 1'b1, 8'h13);
        wait_rx("t3_rx_cnt_a", 3, 400);
        push(0, 1'b1, 8'h20);
        push(3, 1'b1, 8'h23);
        wait_rx("t3_rx_cnt_b", 5, 400);
        chk("t3_grants", gnt_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_gid%0d", i), gnt_q[i], t3_g[i]);
            chk($sformatf("t3_byte%0d", i), rx_q[i], t3_d[i]);
        end
        chk("t3_msg_gap", rx_s[1] - rx_s[0], 82);

        // 4: a 3-byte message is not interleaved with a waiting requester
        do_reset();
        clear_logs();
        push(1, 1'b0, 8'hA1);
        push(1, 1'b0, 8'hA2);
        push(1, 1'b1, 8'hA3);
        tick(1);
        push(0, 1'b1, 8'hB0);
        wait_rx("t4_rx_cnt_a", 3, 500);
        chk("t4_rdy0_quiet", rdy0_cnt, 0);
        chk("t4_one_grant", gnt_q.size(), 1);
        wait_rx("t4_rx_cnt_b", 4, 300);
        chk("t4_gid_first", gnt_q[0], 1);
        chk("t4_gid_second", gnt_q[1], 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_byte%0d", i), rx_q[i], t4_d[i]);

        // 5: grant revoked after 16 idle GRANT cycles
        do_reset();
        clear_logs();
        push(0, 1'b0, 8'h33);
        push(1, 1'b1, 8'h44);
        wait_rx("t5_rx_cnt_a", 1, 200);
        tick(25);
        chk("t5_to_count", to_c.size(), 1);
        chk("t5_to_cycle", to_c[0], rx_s[0] + FRAME + 16);
        chk("t5_to_gv", to_gv, 0);
        wait_rx("t5_rx_cnt_b", 2, 200);
        chk("t5_next_gid", gnt_q[1], 1);
        chk("t5_next_grant_cyc", gnt_c[1], to_c[0] + 1);
        chk("t5_next_byte", rx_q[1], 8'h44);

        // 6: CR/LF trailer (only with UART_ARB_AUTO_CRLF_EN)
        do_reset();
        clear_logs();
        push(2, 1'b1, 8'h58);
`ifdef UART_ARB_AUTO_CRLF_EN
        wait_rx("t6_rx_cnt", 3, 500);
        tick(3);
        chk("t6_b0", rx_q[0], 8'h58);
        chk("t6_cr", rx_q[1], 8'h0D);
        chk("t6_lf", rx_q[2], 8'h0A);
        chk("t6_cr_start", rx_s[1], rx_s[0] + FRAME);
        chk("t6_lf_start", rx_s[2], rx_s[0] + 2 * FRAME);
        chk("t6_gv_fall", gv_fall, rx_s[0] + 3 * FRAME);
`else
        wait_rx("t6_rx_cnt", 1, 200);
        tick(150);
        chk("t6_only_one", rx_q.size(), 1);
        chk("t6_b0", rx_q[0], 8'h58);
        chk("t6_gv_fall", gv_fall, rx_s[0] + FRAME);
`endif
        chk("t6_grants", gnt_q.size(), 1);

        chk("frame_err", frame_err, 0);
        chk("multi_ready", multi_rdy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
